fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
- Read-side consumer placed directly downstream of the async FIFO, in the rclk domain.
- Drains the FIFO's pop interface (r_en/data_out/empty, 1-cycle read latency) and presents the words as a registered valid/ready stream.
- A 3-entry skid buffer holds prefetched words, so there is no combinational path from m_ready to r_en and sustained throughput is 1 word/cycle.
- Also provides a flush and a delivered-word counter.

Parameters:
FIFO_WIDTH, 32, data word width (matches FIFO data_in/data_out)
CNT_WIDTH, 16, width of words_out counter

Ports:
rclk  input  1  read-domain clock; all logic on rising edge
rrst  input  1  synchronous, active-high reset
empty  input  1  FIFO empty flag (rclk domain)
data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted pop
r_en  output  1  FIFO pop request
flush  input  1  synchronous drop of all buffered/in-flight words
m_valid  output  1  stream word valid
m_data  output  FIFO_WIDTH  stream word
m_ready  input  1  downstream accepts word
words_out  output  CNT_WIDTH  count of completed m_valid&&m_ready handshakes
busy  output  1  occ!=0 or inflight

Behaviour:
- Clock and reset: one clock (rclk); reset (rrst) is synchronous and active-high.
- Reset values: occ=0, wr_idx=0, rd_idx=0, inflight=0, state=S_EMPTY, m_valid=0, m_data=0, words_out=0, busy=0, r_en=0. r_en is forced 0 while rrst=1.
- Storage:
  - 3-entry array; wr_idx and rd_idx wrap 2->0 (not power-of-2; no bit-slice wrap).
  - occ is 0..3.
- Pop request:
  - r_en = !rrst && !flush && !empty && (occ + inflight < 3).
  - r_en depends only on registered state plus the empty and flush inputs; it must not depend on m_ready.
- Pop timing:
  - r_en=1 at edge E sets inflight=1.
  - At edge E+1, data_out is written to entry wr_idx, wr_idx advances, and inflight clears unless r_en=1 again.
- Latency: empty falls in cycle N (r_en=1 in N) -> m_valid=1 in cycle N+2.
- Stream output:
  - m_valid = (occ!=0), registered state.
  - m_data = entry[rd_idx], held stable while m_valid && !m_ready.
  - Handshake = m_valid && m_ready: rd_idx advances and words_out increments, wrapping at 2^CNT_WIDTH.
- FSM on occ:
  - S_EMPTY(0) -> S_PART on push.
  - S_PART(1-2) -> S_EMPTY on pop with occ=1 and no push.
  - S_PART -> S_FULL on push with occ=2 and no pop.
  - S_FULL(3) -> S_PART on pop.
  - A push and a pop in the same cycle keep occ unchanged.
  - S_FULL with push is impossible by the credit rule.
- Throughput: with m_ready=1 and the FIFO never empty, steady state is occ=1, inflight=1, one handshake per cycle.
- Ordering: words are delivered exactly in FIFO pop order, with no duplication or loss except on flush or reset.
- flush=1 at an edge:
  - occ=0, indices=0, m_valid=0 the next cycle, inflight=0.
  - A word returning from a pop issued the cycle before flush is discarded.
  - words_out is not cleared.
  - r_en=0 while flush=1; normal operation resumes the cycle after flush deasserts.
- Reset mid-operation: identical to flush, plus words_out=0. The FIFO is reset by its own domain resets; this block makes no assumption about FIFO contents after reset.
- empty asserting while inflight=1: the in-flight word is still captured. empty affects new pops only.
- m_ready is a don't-care while m_valid=0; m_ready=1 with m_valid=0 counts nothing.

Test Plan:
- Reset: hold rrst=1 for 3 cycles with empty=0 -> r_en=0, m_valid=0, m_data=0, words_out=0 throughout.
- Single word: empty falls at cycle 10 with data_out=0xA5A5_0001 -> r_en=1 at cycle 10, m_valid=1 with m_data=0xA5A5_0001 at cycle 12; m_ready=1 -> words_out=1, m_valid=0.
- Backpressure/full:
  - FIFO holds 8 words 0x0..0x7, m_ready=0 -> exactly 3 r_en pulses, then r_en=0 with occ=3 and m_data=0x0 held stable.
  - Release m_ready -> words 0x0..0x7 in order, words_out=8.
- Streaming: FIFO holds 100 words, m_ready=1 -> after 2-cycle latency, 100 consecutive handshakes with no bubbles; indices wrap 2->0 correctly.
- Flush with in-flight word: occ=2, r_en=1 at cycle N, flush=1 at N+1 -> m_valid=0 at N+2, in-flight word not delivered, words_out unchanged, r_en resumes at N+2 if empty=0.
- Mid-stream reset: rrst=1 for 1 cycle during streaming -> all outputs return to reset values the next cycle, and delivery restarts cleanly from the next popped word.

Source files
------------

// File: rtl/fifo_rd_stream_adapter_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_adapter_if
// Groups the FIFO pop side and the valid/ready stream side of the read
// adapter into one bundle.
//   empty    : FIFO empty flag                  (FIFO -> adapter)
//   data_out : FIFO read data, 1 cycle after pop (FIFO -> adapter)
//   r_en     : FIFO pop request                 (adapter -> FIFO)
//   m_valid  : stream word valid                (adapter -> sink)
//   m_data   : stream word                      (adapter -> sink)
//   m_ready  : sink accepts word                (sink -> adapter)
// master = adapter side, slave = FIFO/sink environment side.
// ----------------------------------------------------------------------------
interface fifo_rd_stream_adapter_if #(
    parameter int FIFO_WIDTH = 32
);
    logic                  empty;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  r_en;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  empty,
        input  data_out,
        input  m_ready,
        output r_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output empty,
        output data_out,
        output m_ready,
        input  r_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream_adapter
// Drains an async FIFO's read port (1-cycle read latency) into a registered
// valid/ready stream through a 3-entry skid buffer. Pops are issued on a
// credit basis (buffered + in-flight < 3), so r_en never depends on m_ready
// and a continuously ready sink sees one word per cycle.
// Ports:
//   rclk      : read-domain clock, rising edge
//   rrst      : synchronous active-high reset
//   flush     : synchronous drop of buffered and in-flight words
//   bus       : FIFO pop + stream handshake signals (master modport)
//   words_out : count of completed m_valid && m_ready handshakes (wraps)
//   busy      : buffer non-empty or a pop is in flight
// ----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    flush,
    fifo_rd_stream_adapter_if.master bus,
    output logic [CNT_WIDTH-1:0]    words_out,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [FIFO_WIDTH-1:0] r_mem [0:2];
    logic [1:0]            r_occ;
    logic [1:0]            r_wr_idx;
    logic [1:0]            r_rd_idx;
    logic                  r_inflight;
    logic                  r_m_valid;
    logic [FIFO_WIDTH-1:0] r_m_data;
    logic [CNT_WIDTH-1:0]  r_words_out;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_r_en;
    logic [1:0]            w_occ_next;
    logic [1:0]            w_wr_idx_next;
    logic [1:0]            w_rd_idx_next;
    logic                  w_inflight_next;
    logic [FIFO_WIDTH-1:0] w_m_data_next;

    // Index increment for a 3-deep ring: wraps 2 -> 0.
    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
    endfunction

    // A word lands whenever a pop was issued last cycle.
    assign w_push = r_inflight;
    assign w_pop  = r_m_valid && bus.m_ready;

    // Pop request: credit check on registered state only, never on m_ready.
    always_comb begin
        w_r_en = 1'b0;
        if (!rrst && !flush && !bus.empty &&
            (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3)) begin
            w_r_en = 1'b1;
        end else begin
            w_r_en = 1'b0;
        end
    end

    // Next-state of occupancy, ring indices, in-flight flag and output word.
    always_comb begin
        w_occ_next      = r_occ;
        w_wr_idx_next   = r_wr_idx;
        w_rd_idx_next   = r_rd_idx;
        w_inflight_next = 1'b0;
        w_m_data_next   = r_m_data;
        if (flush) begin
            w_occ_next      = 2'd0;
            w_wr_idx_next   = 2'd0;
            w_rd_idx_next   = 2'd0;
            w_inflight_next = 1'b0;
            w_m_data_next   = {FIFO_WIDTH{1'b0}};
        end else begin
            w_inflight_next = w_r_en;
            w_wr_idx_next   = w_push ? idx_inc(r_wr_idx) : r_wr_idx;
            w_rd_idx_next   = w_pop  ? idx_inc(r_rd_idx) : r_rd_idx;
            case ({w_push, w_pop})
                2'b10:   w_occ_next = r_occ + 2'd1;
                2'b01:   w_occ_next = r_occ - 2'd1;
                default: w_occ_next = r_occ;
            endcase
            // The next head equals the write slot only when the buffer drains
            // to empty this cycle; then the arriving word is the new head.
            if (w_push && (w_rd_idx_next == r_wr_idx)) begin
                w_m_data_next = bus.data_out;
            end else begin
                w_m_data_next = r_mem[w_rd_idx_next];
            end
        end
    end

    // FSM next-state: tracks buffer fill level (empty / partial / full).
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_next = S_PART;
                    end else begin
                        w_state_next = S_EMPTY;
                    end
                end
                S_PART: begin
                    if (w_pop && !w_push && (r_occ == 2'd1)) begin
                        w_state_next = S_EMPTY;
                    end else if (w_push && !w_pop && (r_occ == 2'd2)) begin
                        w_state_next = S_FULL;
                    end else begin
                        w_state_next = S_PART;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_next = S_PART;
                    end else begin
                        w_state_next = S_FULL;
                    end
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: storage, indices, registered stream outputs, counter.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= {FIFO_WIDTH{1'b0}};
            end
            r_occ       <= 2'd0;
            r_wr_idx    <= 2'd0;
            r_rd_idx    <= 2'd0;
            r_inflight  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= {FIFO_WIDTH{1'b0}};
            r_words_out <= {CNT_WIDTH{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            if (!flush && w_push) begin
                r_mem[r_wr_idx] <= bus.data_out;
            end
            // A handshake in the flush cycle was still accepted downstream.
            if (w_pop) begin
                r_words_out <= r_words_out + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            r_occ      <= w_occ_next;
            r_wr_idx   <= w_wr_idx_next;
            r_rd_idx   <= w_rd_idx_next;
            r_inflight <= w_inflight_next;
            r_m_valid  <= (w_state_next != S_EMPTY);
            r_m_data   <= w_m_data_next;
            r_busy     <= (w_state_next != S_EMPTY) || w_inflight_next;
        end
    end

    assign bus.r_en    = w_r_en;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign words_out   = r_words_out;
    assign busy        = r_busy;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        flush;
    logic [15:0] words_out;
    logic        busy;

    always #5 rclk = ~rclk;

    fifo_rd_stream_adapter_if #(.FIFO_WIDTH(32)) bus ();

    fifo_rd_stream_adapter #(.FIFO_WIDTH(32), .CNT_WIDTH(16)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .flush     (flush),
        .bus       (bus),
        .words_out (words_out),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // FIFO model and reference model state
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];      // words landed in the adapter, head first
    bit          pend;          // a popped word is returning next edge
    int unsigned cnt;           // expected handshake count
    int          rpulses;
    int          ncyc;
    logic [31:0] dut_seen[$];
    int          hs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        bus.empty = 1'b0;
    endtask

    // One clock: compare at negedge, then advance model and FIFO after edge.
    task automatic cycle();
        logic pop_s, hs_s, m_en, m_hs;
        @(negedge rclk);
        m_en = !rrst && !flush && !bus.empty && ((buf_q.size() + pend) < 3);
        m_hs = (buf_q.size() != 0) && bus.m_ready;
        chk("r_en", {31'd0, bus.r_en}, {31'd0, m_en});
        chk("m_valid", {31'd0, bus.m_valid}, {31'd0, buf_q.size() != 0});
        if (buf_q.size() != 0) chk("m_data", bus.m_data, buf_q[0]);
        chk("words_out", {16'd0, words_out}, cnt & 32'hFFFF);
        chk("busy", {31'd0, busy}, {31'd0, (buf_q.size() != 0) || pend});
        pop_s = bus.r_en;
        hs_s  = bus.m_valid && bus.m_ready;
        if (hs_s) begin
            dut_seen.push_back(bus.m_data);
            hs_cyc.push_back(ncyc);
        end
        @(posedge rclk);
        #1;
        if (rrst) begin
            buf_q.delete();
            pend = 1'b0;
            cnt  = 0;
        end else if (flush) begin
            if (m_hs) cnt++;
            buf_q.delete();
            pend = 1'b0;
        end else begin
            if (m_hs) begin
                void'(buf_q.pop_front());
                cnt++;
            end
            if (pend) buf_q.push_back(bus.data_out);
            pend = m_en;
        end
        if (pop_s) begin
            rpulses++;
            if (fifo_q.size() != 0) bus.data_out = fifo_q.pop_front();
            else bus.data_out = $urandom();
        end else begin
            bus.data_out = $urandom();
        end
        bus.empty = (fifo_q.size() == 0);
        ncyc++;
    endtask

    initial begin
        int          w0, p0, lcyc;
        logic [31:0] sexp[$];

        rrst = 1'b1; flush = 1'b0; bus.m_ready = 1'b0;
        bus.data_out = 32'd0; bus.empty = 1'b1;
        pend = 1'b0; cnt = 0; rpulses = 0; ncyc = 0;

        // Reset held 3 cycles with FIFO non-empty
        load(32'hA5A5_0001);
        repeat (3) begin
            cycle();
            chk("rst_m_data", bus.m_data, 32'd0);
        end

        // Single word: 2-cycle latency
        rrst = 1'b0;
        cycle();
        cycle();
        chk("single_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("single_data", bus.m_data, 32'hA5A5_0001);
        bus.m_ready = 1'b1;
        cycle();
        chk("single_cnt", {16'd0, words_out}, 32'd1);
        chk("single_drop", {31'd0, bus.m_valid}, 32'd0);

        // Backpressure: exactly 3 pops, head held
        bus.m_ready = 1'b0;
        p0 = rpulses;
        w0 = words_out;
        for (int i = 0; i < 8; i++) load(i);
        repeat (10) cycle();
        chk("bp_pulses", rpulses - p0, 32'd3);
        chk("bp_head", bus.m_data, 32'd0);
        dut_seen.delete();
        bus.m_ready = 1'b1;
        repeat (15) cycle();
        chk("bp_count", dut_seen.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("bp_order", (i < dut_seen.size()) ? dut_seen[i] : 32'hxxxx_xxxx, i);
        chk("bp_words", words_out - w0, 32'd8);

        // Streaming 100 words, no bubbles
        dut_seen.delete();
        hs_cyc.delete();
        lcyc = ncyc;
        for (int i = 0; i < 100; i++) begin
            sexp.push_back($urandom());
            load(sexp[i]);
        end
        repeat (110) cycle();
        chk("st_count", dut_seen.size(), 32'd100);
        if (hs_cyc.size() == 100) begin
            chk("st_latency", hs_cyc[0] - lcyc, 32'd2);
            chk("st_nobubble", hs_cyc[99] - hs_cyc[0], 32'd99);
            for (int i = 0; i < 100; i++) chk("st_order", dut_seen[i], sexp[i]);
        end

        // Flush with a word in flight
        bus.m_ready = 1'b0;
        load(32'h0000_00F0);
        load(32'h0000_00F1);
        repeat (5) cycle();
        load(32'h0000_00F2);
        load(32'h0000_00F3);
        load(32'h0000_00F4);
        dut_seen.delete();
        w0 = words_out;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("fl_words", {16'd0, words_out}, w0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        cycle();
        bus.m_ready = 1'b1;
        repeat (8) cycle();
        chk("fl_count", dut_seen.size(), 32'd2);
        if (dut_seen.size() == 2) begin
            chk("fl_w0", dut_seen[0], 32'h0000_00F3);
            chk("fl_w1", dut_seen[1], 32'h0000_00F4);
        end

        // Mid-stream reset
        for (int i = 0; i < 20; i++) load(32'hC000_0000 + i);
        repeat (6) cycle();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        chk("mr_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("mr_data", bus.m_data, 32'd0);
        chk("mr_words", {16'd0, words_out}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        repeat (30) cycle();

        // Randomized traffic with occasional flush
        repeat (400) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 10) load($urandom());
            bus.m_ready = $urandom_range(0, 1);
            flush = ($urandom_range(0, 24) == 0);
            cycle();
        end
        flush = 1'b0;
        bus.m_ready = 1'b1;
        repeat (20) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
